// File: rtl/spike_window_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_window_decoder
// Description : Rate-code read-out for the WTA spike network. Counts spikes
//               per channel over a programmable window, snapshots the counts
//               and runs a sequential argmax while the next window counts.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_window_decoder #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_CH-1:0]     spikes,
    input  logic [7:0]          win_len,
    output logic [IDX_W-1:0]    winner,
    output logic [CNT_W-1:0]    win_count,
    output logic                tie,
    output logic                silent,
    output logic                valid,
    output logic                busy
);

    // Shortest legal window: the argmax (N_CH cycles) must finish before
    // the next snapshot overwrites the compare source.
    localparam logic [7:0]       MIN_LEN = 8'(2 * N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;
    localparam logic [0:0] C_IDLE  = 1'b0;
    localparam logic [0:0] C_CMP   = 1'b1;

    // Counting side
    logic [0:0]                 state_q, state_d;
    logic [7:0]                 len_q, len_d;
    logic [7:0]                 wcnt_q, wcnt_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0][CNT_W-1:0] snap_q, snap_d;
    logic [N_CH-1:0][CNT_W-1:0] sum_w;
    logic [7:0]                 clamp_w;
    logic [7:0]                 len_w;
    logic                       start_w;

    // Compare side
    logic [0:0]                 cstate_q, cstate_d;
    logic [IDX_W-1:0]           k_q, k_d;
    logic [CNT_W-1:0]           max_q, max_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       rtie_q, rtie_d;
    logic [CNT_W-1:0]           cur_w;
    logic [CNT_W-1:0]           nmax_w;
    logic [IDX_W-1:0]           nidx_w;
    logic                       ntie_w;

    // Result registers
    logic [IDX_W-1:0]           winner_q, winner_d;
    logic [CNT_W-1:0]           wcount_q, wcount_d;
    logic                       tie_q, tie_d;
    logic                       silent_q, silent_d;
    logic                       valid_q, valid_d;

    assign winner    = winner_q;
    assign win_count = wcount_q;
    assign tie       = tie_q;
    assign silent    = silent_q;
    assign valid     = valid_q;
    assign busy      = (state_q == S_COUNT);

    // Saturating per-channel increment for this cycle's spikes
    always_comb begin
        sum_w = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_q[i] != CNT_MAX) begin
                sum_w[i] = cnt_q[i] + CNT_W'(spikes[i]);
            end
        end
    end

    // Window length: clamped, and only taken from win_len on the first
    // cycle of a window (window counter at zero), latched otherwise
    always_comb begin
        clamp_w = (win_len < MIN_LEN) ? MIN_LEN : win_len;
        len_w   = (wcnt_q == 8'd0) ? clamp_w : len_q;
    end

    // Window counter FSM: IDLE counts its first enabled cycle as window
    // cycle 0; the last cycle snapshots and rolls straight into a new window
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        start_w = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            wcnt_d  = 8'd0;
            cnt_d   = '0;
        end else begin
            state_d = S_COUNT;
            len_d   = len_w;
            if (wcnt_q == len_w - 8'd1) begin
                snap_d  = sum_w;
                cnt_d   = '0;
                wcnt_d  = 8'd0;
                start_w = 1'b1;
            end else begin
                cnt_d   = sum_w;
                wcnt_d  = wcnt_q + 8'd1;
            end
        end
    end

    // Counting-side state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= MIN_LEN;
            wcnt_q  <= 8'd0;
            cnt_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

    // One argmax step on snapshot channel k: strictly greater replaces the
    // running max (lowest index wins ties), equal nonzero flags a tie
    always_comb begin
        cur_w  = snap_q[k_q];
        nmax_w = max_q;
        nidx_w = idx_q;
        ntie_w = rtie_q;
        if (cur_w > max_q) begin
            nmax_w = cur_w;
            nidx_w = k_q;
            ntie_w = 1'b0;
        end else if ((cur_w == max_q) && (max_q != '0)) begin
            ntie_w = 1'b1;
        end
    end

    // Compare engine FSM: N_CH compare cycles, then a one-cycle result strobe
    always_comb begin
        cstate_d = cstate_q;
        k_d      = k_q;
        max_d    = max_q;
        idx_d    = idx_q;
        rtie_d   = rtie_q;
        winner_d = winner_q;
        wcount_d = wcount_q;
        tie_d    = tie_q;
        silent_d = silent_q;
        valid_d  = 1'b0;
        case (cstate_q)
            C_IDLE: begin
                if (start_w) begin
                    cstate_d = C_CMP;
                    k_d      = '0;
                    max_d    = '0;
                    idx_d    = '0;
                    rtie_d   = 1'b0;
                end
            end
            C_CMP: begin
                max_d  = nmax_w;
                idx_d  = nidx_w;
                rtie_d = ntie_w;
                if (k_q == LAST_CH) begin
                    cstate_d = C_IDLE;
                    valid_d  = 1'b1;
                    silent_d = (nmax_w == '0);
                    winner_d = (nmax_w == '0) ? '0 : nidx_w;
                    wcount_d = nmax_w;
                    tie_d    = (nmax_w == '0) ? 1'b0 : ntie_w;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    // Compare-side and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstate_q <= C_IDLE;
            k_q      <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            rtie_q   <= 1'b0;
            winner_q <= '0;
            wcount_q <= '0;
            tie_q    <= 1'b0;
            silent_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            cstate_q <= cstate_d;
            k_q      <= k_d;
            max_q    <= max_d;
            idx_q    <= idx_d;
            rtie_q   <= rtie_d;
            winner_q <= winner_d;
            wcount_q <= wcount_d;
            tie_q    <= tie_d;
            silent_q <= silent_d;
            valid_q  <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_window_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_window_decoder
// Description : Directed + random bench for spike_window_decoder against a
//               window-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_window_decoder;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int IDX_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [N_CH-1:0]   spikes;
    logic [7:0]        win_len;
    logic [IDX_W-1:0]  winner;
    logic [CNT_W-1:0]  win_count;
    logic              tie;
    logic              silent;
    logic              valid;
    logic              busy;

    spike_window_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spikes    (spikes),
        .win_len   (win_len),
        .winner    (winner),
        .win_count (win_count),
        .tie       (tie),
        .silent    (silent),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int idx;
        int cnt;
        bit tie;
        bit silent;
    } res_t;

    res_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;

    // Reference model state: one open window at most
    bit   m_in_win = 1'b0;
    int   m_len    = 0;
    int   m_pos    = 0;
    int   m_cnt[N_CH];

    int   e_winner = 0;
    int   e_count  = 0;
    bit   e_tie    = 1'b0;
    bit   e_silent = 1'b0;
    bit   e_valid  = 1'b0;
    bit   e_busy   = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    // Window closed: plain argmax over the counts, result due N_CH edges later
    function automatic void close_window();
        int   m   = 0;
        int   idx = 0;
        bit   t   = 1'b0;
        res_t r;
        for (int j = 0; j < N_CH; j++) begin
            if (m_cnt[j] > m) begin
                m   = m_cnt[j];
                idx = j;
            end
        end
        for (int j = 0; j < N_CH; j++) begin
            if (j != idx && m_cnt[j] == m && m != 0) t = 1'b1;
        end
        r.due    = edge_n + N_CH;
        r.idx    = idx;
        r.cnt    = m;
        r.tie    = t;
        r.silent = (m == 0);
        q.push_back(r);
    endfunction

    task automatic model_step();
        int wl;
        edge_n++;
        e_valid = 1'b0;
        if (!rst_n) begin
            m_in_win = 1'b0;
            q.delete();
            e_winner = 0;
            e_count  = 0;
            e_tie    = 1'b0;
            e_silent = 1'b0;
            e_busy   = 1'b0;
        end else begin
            e_busy = en;
            if (!en) begin
                m_in_win = 1'b0;
            end else begin
                if (!m_in_win) begin
                    m_in_win = 1'b1;
                    wl       = int'(win_len);
                    m_len    = (wl < 2 * N_CH) ? 2 * N_CH : wl;
                    m_pos    = 0;
                    for (int j = 0; j < N_CH; j++) m_cnt[j] = 0;
                end
                for (int j = 0; j < N_CH; j++) begin
                    if (spikes[j] && m_cnt[j] < SAT) m_cnt[j]++;
                end
                m_pos++;
                if (m_pos == m_len) begin
                    close_window();
                    m_in_win = 1'b0;
                end
            end
            if (q.size() > 0 && q[0].due == edge_n) begin
                e_valid  = 1'b1;
                e_winner = q[0].idx;
                e_count  = q[0].cnt;
                e_tie    = q[0].tie;
                e_silent = q[0].silent;
                void'(q.pop_front());
            end
        end
    endtask

    // One clock: drive at negedge, step model at posedge, compare just after
    task automatic cycle(input bit r, input bit e, input logic [N_CH-1:0] s, input int wl);
        @(negedge clk);
        rst_n   = r;
        en      = e;
        spikes  = s;
        win_len = wl[7:0];
        if (!r) begin
            #1;
            check("async_clr_valid",  valid,  0);
            check("async_clr_winner", winner, 0);
        end
        @(posedge clk);
        model_step();
        #1;
        check("valid",     valid,     e_valid);
        check("busy",      busy,      e_busy);
        check("winner",    winner,    e_winner);
        check("win_count", win_count, e_count);
        check("tie",       tie,       e_tie);
        check("silent",    silent,    e_silent);
    endtask

    initial begin
        logic [N_CH-1:0] s;
        bit              r;
        bit              e;
        int              wl;
        rst_n   = 1'b0;
        en      = 1'b0;
        spikes  = '0;
        win_len = 8'd8;

        // Reset state
        repeat (3) cycle(1'b0, 1'b0, '0, 8);

        // Single active channel, win_len=10
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'b0001, 10);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 4'b0000, 10);
        repeat (8) cycle(1'b1, 1'b0, '0, 10);

        // Tie between ch2 and ch3 at 7, ch1 at 5
        for (int i = 0; i < 20; i++) begin
            s = {(i < 7), (i < 7), (i < 5), 1'b0};
            cycle(1'b1, 1'b1, s, 20);
        end
        repeat (8) cycle(1'b1, 1'b0, '0, 20);

        // Clamped short window, silence
        repeat (40) cycle(1'b1, 1'b1, '0, 3);
        repeat (6) cycle(1'b1, 1'b0, '0, 3);

        // Full-length windows with ch1 held high
        repeat (520) cycle(1'b1, 1'b1, 4'b0010, 255);
        repeat (6) cycle(1'b1, 1'b0, '0, 255);

        // Abort at cycle 5, gap of 3, then a fresh 16-cycle ch3 window
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 4'b1000, 16);
        repeat (3) cycle(1'b1, 1'b0, 4'b1000, 16);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 4'b1000, 16);
        repeat (8) cycle(1'b1, 1'b1, '0, 16);
        repeat (6) cycle(1'b1, 1'b0, '0, 16);

        // Reset while the argmax is running
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 4'($urandom), 8);
        cycle(1'b1, 1'b1, '0, 8);
        repeat (3) cycle(1'b0, 1'b1, '0, 8);
        repeat (10) cycle(1'b1, 1'b0, '0, 8);

        // Random traffic with occasional disables and resets
        for (int i = 0; i < 2500; i++) begin
            r  = ($urandom_range(0, 599) != 0);
            e  = ($urandom_range(0, 39) != 0);
            wl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(8, 40);
            s  = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 2) == 0) s = s | 4'(1 << $urandom_range(0, N_CH - 1));
            cycle(r, e, s, wl);
        end
        repeat (10) cycle(1'b1, 1'b0, '0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spike_window_decoder.md
Name: spike_window_decoder

Overview:
- Read-out end of the winner-take-all spike network: consumes the per-neuron spike lines that the WTA core produces and decodes them into a rate-coded result.
- Counts spikes per channel over a programmable window of clock cycles, then runs a sequential argmax over the snapshot. Reports winner index, winner count, tie and silence flags with a one-cycle valid strobe.
- Double-buffered: counting of the next window proceeds while the argmax of the previous window runs.

Parameters:
- N_CH, 4, number of spike input channels (>=2).
- CNT_W, 8, width of per-channel spike counters (saturating).
- IDX_W, 2, width of winner index; must equal clog2(N_CH).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- en  input  1  decoder enable; low aborts any window in progress
- spikes  input  N_CH  one spike bit per neuron, sampled every cycle
- win_len  input  8  window length in cycles, sampled at window start
- winner  output  IDX_W  index of channel with the highest count
- win_count  output  CNT_W  spike count of the winner
- tie  output  1  another channel equals the winner's nonzero count
- silent  output  1  all channels counted zero in the window
- valid  output  1  one-cycle strobe: result outputs updated this cycle
- busy  output  1  high while a window is being counted (state COUNT)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters, snapshot and window counter 0; winner=0, win_count=0, tie=0, silent=0, valid=0, busy=0.
- Effective window length: L = win_len, except values below 2*N_CH are forced to 2*N_CH (default 8). This guarantees the compare finishes before the next snapshot.
- Counter FSM (states IDLE, COUNT):
  - IDLE -> COUNT on first cycle with en=1; L latched. Spikes are counted starting that same cycle.
  - COUNT: each cycle, cnt[i] += spikes[i], saturating at 2^CNT_W-1. Window counter runs 0..L-1.
  - Last cycle (window counter = L-1): snap[i] = sat(cnt[i] + spikes[i]). Counters clear to 0, a new window starts next cycle with win_len re-sampled, and the compare engine starts.
  - Window boundaries are back-to-back with no gap cycles.
- Compare engine (states CIDLE, CMP):
  - CMP takes exactly N_CH cycles, examining channel k in cycle k.
  - Running max is replaced only if snap[k] > max, which is strictly greater, so the lowest index wins ties.
  - tie is set when snap[k] == max and max != 0; it is cleared when a new strict max is found.
  - The cycle after the last compare: winner, win_count, tie and silent are registered and valid=1 for exactly one cycle. silent=1 iff max == 0, in which case winner=0, win_count=0, tie=0.
  - Result outputs hold until the next valid.
  - Latency: valid asserts N_CH+1 cycles after the last cycle of the window.
- en=0 in any state: next edge goes to IDLE and clears counters and the window counter. A compare already in flight completes and still issues valid; its result is legal. busy drops the cycle after en falls.
- Saturation: a counter at max stays at max; it does not wrap.
- Reset mid-window or mid-compare: everything returns to reset values immediately, and no valid is issued.

Test Plan:
- Reset, en=1, win_len=10, spikes=4'b0001 every cycle for 10 cycles, then 0 -> valid 5 cycles after window end; winner=0, win_count=10, tie=0, silent=0.
- win_len=20: ch2 spikes 7 times, ch1 5 times, ch3 7 times -> winner=2, win_count=7, tie=1.
- win_len=3 (clamped to 8), spikes=0 -> valid every 8 cycles with silent=1, winner=0, win_count=0; valid spacing exactly 8 cycles.
- CNT_W=8, win_len=255 followed by win_len=255 with ch1 held high -> win_count=255 both windows, no wrap. Back-to-back valids 255 cycles apart; a spike on the boundary cycle is counted in the ending window.
- Drop en at cycle 5 of a 16-cycle window, re-raise 3 cycles later -> no valid for the aborted window, busy low during the gap. The new window counts from zero: 16 cycles of ch3 spikes -> winner=3, win_count=16.
- Assert rst_n=0 during the CMP state -> valid never pulses, outputs read 0; operation restarts cleanly after release.
